avalon_st_sink_checker: RTL and testbench

Avalon-ST sink for the 8-bit counting stream (4,5,6,4,5,6,...) produced by our streaming source.
- Accepts beats through a valid/ready handshake into a small first-word-fall-through FIFO.
- Re-presents the buffered beats on a downstream valid/ready port.
- Runs a sequence-checker FSM on every accepted beat, with lock/error status and counters.

---
 rtl/avalon_st_sink_checker.sv | 186 ++++++++++++++++++
 tb/tb_avalon_st_sink_checker.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/avalon_st_sink_checker.sv
// avalon_st_sink_checker
// Avalon-ST sink for the repeating counting stream (SEQ_FIRST, +1, +2, ...).
// Accepted beats go into a first-word-fall-through FIFO, which drives a
// downstream valid/ready port. A checker FSM watches every accepted beat and
// reports lock, error pulses, a beat counter and a saturating error counter.
//
// Optional build macro: SINK_BACKPRESSURE_EN
//   When defined, an 8-bit Fibonacci LFSR (taps 8,6,5,4, seed 8'hA5) gates
//   in_ready so that upstream stall handling gets exercised.
//   When undefined, in_ready depends only on FIFO occupancy.

module avalon_st_sink_checker #(
  parameter int          DEPTH     = 4,
  parameter int          CNT_W     = 16,
  parameter logic [7:0]  SEQ_FIRST = 8'h04
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_data,
  output logic             seq_locked,
  output logic             seq_error,
  output logic [CNT_W-1:0] beat_count,
  output logic [7:0]       err_count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = (AW)'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);

  // The three values of the repeating triple, computed modulo 256.
  localparam logic [7:0] SEQ_V0 = SEQ_FIRST;
  localparam logic [7:0] SEQ_V1 = SEQ_FIRST + 8'd1;
  localparam logic [7:0] SEQ_V2 = SEQ_FIRST + 8'd2;

  typedef enum logic [1:0] {
    HUNT = 2'd0,
    EXP1 = 2'd1,
    EXP2 = 2'd2,
    EXP0 = 2'd3
  } state_t;

  // Saturating increment for the 8-bit error counter.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    if (v == 8'hFF) return v;
    return v + 8'd1;
  endfunction

  // Wrapping increment for the beat counter.
  function automatic logic [CNT_W-1:0] wrap_inc(input logic [CNT_W-1:0] v);
    return v + (CNT_W)'(1);
  endfunction

  // FIFO storage and control
  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;

  // Checker state and status
  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_viol;
  logic             r_locked;
  logic             r_error;
  logic [CNT_W-1:0] r_beat;
  logic [7:0]       r_errc;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;

  assign w_full  = (r_count == FULL_CNT);
  assign w_empty = (r_count == '0);

`ifdef SINK_BACKPRESSURE_EN
  logic [7:0] r_lfsr;
  logic       w_lfsr_fb;

  assign w_lfsr_fb = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];

  // Free-running LFSR that randomly withholds in_ready.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_lfsr <= 8'hA5;
    else         r_lfsr <= {r_lfsr[6:0], w_lfsr_fb};
  end

  assign in_ready = !w_full && r_lfsr[0];
`else
  assign in_ready = !w_full;
`endif

  assign w_push = in_valid && in_ready;
  assign w_pop  = !w_empty && out_ready;

  // Head of the FIFO falls through; data reads as zero when nothing is held.
  assign out_valid = !w_empty;
  assign out_data  = w_empty ? 8'h00 : r_mem[r_rptr];

  // Storage array is data only and carries no reset.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= in_data;
  end

  // Read/write pointers and occupancy; a full FIFO frees its slot only next cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PTR_ONE;
      if (w_pop)  r_rptr <= r_rptr + PTR_ONE;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Next-state logic of the sequence checker, evaluated against the incoming beat.
  always_comb begin
    w_state_nxt = r_state;
    w_viol      = 1'b0;
    if (w_push) begin
      case (r_state)
        HUNT: begin
          if (in_data == SEQ_V0) w_state_nxt = EXP1;
        end
        EXP1: begin
          if (in_data == SEQ_V1) w_state_nxt = EXP2;
          else                   w_viol      = 1'b1;
        end
        EXP2: begin
          if (in_data == SEQ_V2) w_state_nxt = EXP0;
          else                   w_viol      = 1'b1;
        end
        EXP0: begin
          if (in_data == SEQ_V0) w_state_nxt = EXP1;
          else                   w_viol      = 1'b1;
        end
        default: w_state_nxt = HUNT;
      endcase
      // A bad beat that is itself the triple's first value restarts tracking at once.
      if (w_viol) w_state_nxt = (in_data == SEQ_V0) ? EXP1 : HUNT;
    end
  end

  // Checker state register with the lock flag registered alongside it.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state  <= HUNT;
      r_locked <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_locked <= (w_state_nxt != HUNT);
    end
  end

  // Error pulse, saturating error counter and wrapping beat counter.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_error <= 1'b0;
      r_errc  <= 8'h00;
      r_beat  <= '0;
    end else begin
      r_error <= w_viol;
      if (w_viol) r_errc <= sat_inc8(r_errc);
      if (w_push) r_beat <= wrap_inc(r_beat);
    end
  end

  assign seq_locked = r_locked;
  assign seq_error  = r_error;
  assign beat_count = r_beat;
  assign err_count  = r_errc;

endmodule

// File: tb/tb_avalon_st_sink_checker.sv
// Directed bench for avalon_st_sink_checker: table of per-cycle vectors with
// hand-computed expectations, plus hand-written reset, full-FIFO and long
// streaming sequences.
module tb_avalon_st_sink_checker;

  logic        clk;
  logic        resetn;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        seq_locked;
  logic        seq_error;
  logic [15:0] beat_count;
  logic [7:0]  err_count;

  int total = 0;
  int bad   = 0;

  avalon_st_sink_checker #(.DEPTH(4), .CNT_W(16), .SEQ_FIRST(8'h04)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .seq_locked (seq_locked),
    .seq_error  (seq_error),
    .beat_count (beat_count),
    .err_count  (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       iv;
    logic [7:0] d;
    logic       ordy;
    logic       rdy;
    logic       ov;
    logic [7:0] od;
    logic       lk;
    logic       er;
    int         bc;
    int         ec;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic iv, logic [7:0] d, logic ordy, logic rdy, logic ov,
                              logic [7:0] od, logic lk, logic er, int bc, int ec);
    vec_t v;
    v.iv = iv; v.d = d; v.ordy = ordy; v.rdy = rdy; v.ov = ov;
    v.od = od; v.lk = lk; v.er = er; v.bc = bc; v.ec = ec;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic rdy, input logic ov, input logic [7:0] od,
                         input logic lk, input logic er, input int bc, input int ec);
    chk({tag, ".in_ready"},   int'(in_ready),   int'(rdy));
    chk({tag, ".out_valid"},  int'(out_valid),  int'(ov));
    chk({tag, ".out_data"},   int'(out_data),   int'(od));
    chk({tag, ".seq_locked"}, int'(seq_locked), int'(lk));
    chk({tag, ".seq_error"},  int'(seq_error),  int'(er));
    chk({tag, ".beat_count"}, int'(beat_count), bc);
    chk({tag, ".err_count"},  int'(err_count),  ec);
  endtask

  // Called at a negedge with inputs already set: clock one edge, land on next negedge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    step();
    step();
    resetn = 1'b1;
  endtask

  localparam int NSTREAM = 1000;

  initial begin
    int i;
    int j;
    int cyc;
    int err_seen;
    int rdy_lo;
    int rdy_hi;
    logic acc;
    logic pop;
    logic [7:0] pd;
    logic [7:0] expd;

    resetn = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
    #1;
    chk_all("reset", 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 0, 0);
    @(negedge clk);
    step();
    resetn = 1'b1;
    #1;
    chk("release.in_ready", int'(in_ready), 1);

    // iv, d, ordy | rdy, ov, od, lk, er, beat, errc (values after the edge)
    tbl.push_back(mk(1, 8'h04, 1, 1, 1, 8'h04, 1, 0,  1, 0));
    tbl.push_back(mk(1, 8'h05, 1, 1, 1, 8'h05, 1, 0,  2, 0));
    tbl.push_back(mk(1, 8'h06, 1, 1, 1, 8'h06, 1, 0,  3, 0));
    tbl.push_back(mk(1, 8'h04, 1, 1, 1, 8'h04, 1, 0,  4, 0));
    tbl.push_back(mk(1, 8'h05, 1, 1, 1, 8'h05, 1, 0,  5, 0));
    tbl.push_back(mk(1, 8'h06, 1, 1, 1, 8'h06, 1, 0,  6, 0));
    tbl.push_back(mk(0, 8'h33, 1, 1, 0, 8'h00, 1, 0,  6, 0));
    // 4,5,7,4,5,6: error on 7, back to HUNT, relock on 4
    tbl.push_back(mk(1, 8'h04, 1, 1, 1, 8'h04, 1, 0,  7, 0));
    tbl.push_back(mk(1, 8'h05, 1, 1, 1, 8'h05, 1, 0,  8, 0));
    tbl.push_back(mk(1, 8'h07, 1, 1, 1, 8'h07, 0, 1,  9, 1));
    tbl.push_back(mk(1, 8'h04, 1, 1, 1, 8'h04, 1, 0, 10, 1));
    tbl.push_back(mk(1, 8'h05, 1, 1, 1, 8'h05, 1, 0, 11, 1));
    tbl.push_back(mk(1, 8'h06, 1, 1, 1, 8'h06, 1, 0, 12, 1));
    // 4,5,4,5,6: error on second 4, straight to EXP1, no second error
    tbl.push_back(mk(1, 8'h04, 1, 1, 1, 8'h04, 1, 0, 13, 1));
    tbl.push_back(mk(1, 8'h05, 1, 1, 1, 8'h05, 1, 0, 14, 1));
    tbl.push_back(mk(1, 8'h04, 1, 1, 1, 8'h04, 1, 1, 15, 2));
    tbl.push_back(mk(1, 8'h05, 1, 1, 1, 8'h05, 1, 0, 16, 2));
    tbl.push_back(mk(1, 8'h06, 1, 1, 1, 8'h06, 1, 0, 17, 2));
    tbl.push_back(mk(0, 8'h04, 1, 1, 0, 8'h00, 1, 0, 17, 2));
    // 9 breaks lock; a second 9 while hunting is not an error
    tbl.push_back(mk(1, 8'h09, 1, 1, 1, 8'h09, 0, 1, 18, 3));
    tbl.push_back(mk(1, 8'h09, 1, 1, 1, 8'h09, 0, 0, 19, 3));
    tbl.push_back(mk(1, 8'h04, 1, 1, 1, 8'h04, 1, 0, 20, 3));
    tbl.push_back(mk(0, 8'h00, 1, 1, 0, 8'h00, 1, 0, 20, 3));

    for (int k = 0; k < tbl.size(); k++) begin
      in_valid  = tbl[k].iv;
      in_data   = tbl[k].d;
      out_ready = tbl[k].ordy;
      step();
      chk_all($sformatf("vec%0d", k), tbl[k].rdy, tbl[k].ov, tbl[k].od,
              tbl[k].lk, tbl[k].er, tbl[k].bc, tbl[k].ec);
    end

    // Mid-stream asynchronous reset with three entries buffered.
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 8'h05; step();
    in_data = 8'h06; step();
    in_data = 8'h04; step();
    in_valid = 1'b0;
    chk_all("fill3", 1'b1, 1'b1, 8'h05, 1'b1, 1'b0, 23, 3);
    #2;
    resetn = 1'b0;
    #1;
    chk_all("midrst", 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 0, 0);
    @(negedge clk);
    step();
    resetn = 1'b1;
    step();
    chk("midrst.rel.in_ready", int'(in_ready), 1);
    chk("midrst.rel.out_valid", int'(out_valid), 0);

    // Full FIFO: fourth push drops in_ready, fifth beat waits for a pop.
    out_ready = 1'b0; in_valid = 1'b1;
    in_data = 8'h04; step(); chk_all("full1", 1'b1, 1'b1, 8'h04, 1'b1, 1'b0, 1, 0);
    in_data = 8'h05; step(); chk_all("full2", 1'b1, 1'b1, 8'h04, 1'b1, 1'b0, 2, 0);
    in_data = 8'h06; step(); chk_all("full3", 1'b1, 1'b1, 8'h04, 1'b1, 1'b0, 3, 0);
    in_data = 8'h04; step(); chk_all("full4", 1'b0, 1'b1, 8'h04, 1'b1, 1'b0, 4, 0);
    in_data = 8'h05; step(); chk_all("hold5", 1'b0, 1'b1, 8'h04, 1'b1, 1'b0, 4, 0);
    out_ready = 1'b1;
    step(); chk_all("drain1", 1'b1, 1'b1, 8'h05, 1'b1, 1'b0, 4, 0);
    step(); chk_all("drain2", 1'b1, 1'b1, 8'h06, 1'b1, 1'b0, 5, 0);
    in_valid = 1'b0;
    step(); chk_all("drain3", 1'b1, 1'b1, 8'h04, 1'b1, 1'b0, 5, 0);
    step(); chk_all("drain4", 1'b1, 1'b1, 8'h05, 1'b1, 1'b0, 5, 0);
    step(); chk_all("drain5", 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 5, 0);

    // Long stream with random downstream stalls; order and counts must hold.
    do_reset();
    i = 0; j = 0; cyc = 0; err_seen = 0; rdy_lo = 0; rdy_hi = 0;
    while (j < NSTREAM && cyc < 20000) begin
      in_valid  = (i < NSTREAM);
      in_data   = 8'h04 + 8'(i % 3);
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      acc = in_valid && in_ready;
      pop = out_valid && out_ready;
      pd  = out_data;
      if (in_valid) begin
        if (in_ready) rdy_hi++;
        else          rdy_lo++;
      end
      @(posedge clk);
      if (acc) i++;
      if (pop) begin
        expd = 8'h04 + 8'(j % 3);
        if (pd !== expd) chk($sformatf("stream.data%0d", j), int'(pd), int'(expd));
        j++;
      end
      @(negedge clk);
      if (seq_error) err_seen++;
      cyc++;
    end
    in_valid = 1'b0;
    chk("stream.received", j, NSTREAM);
    chk("stream.accepted", i, NSTREAM);
    chk("stream.beat_count", int'(beat_count), NSTREAM);
    chk("stream.err_count", int'(err_count), 0);
    chk("stream.err_pulses", err_seen, 0);
    chk("stream.locked", int'(seq_locked), 1);
`ifdef SINK_BACKPRESSURE_EN
    chk("stream.ready_toggled", int'(rdy_lo > 0 && rdy_hi > 0), 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
